// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-access sequencer.
//   state_t     : sequencer states
//   BYTE_W      : width of one SPI byte
//   build_frame : packs {rw, addr, wdata} into a right-justified command
//                 frame of (addr_bytes + data_bytes) bytes, MSB first
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RX,
    RESP
  } state_t;

  localparam int unsigned BYTE_W = 8;

  // addr must be zero-extended by the caller. The R/W flag occupies the MSB
  // of the first address byte. Read frames carry zero data bytes.
  function automatic logic [63:0] build_frame(
    input logic              rw,
    input logic [30:0]       addr,
    input logic [31:0]       wdata,
    input int unsigned       addr_bytes,
    input int unsigned       data_bytes
  );
    logic [63:0] hdr;
    hdr = {33'd0, addr} | (64'(rw) << (BYTE_W * addr_bytes - 1));
    return (hdr << (BYTE_W * data_bytes)) | (rw ? 64'd0 : {32'd0, wdata});
  endfunction

endpackage

// File: rtl/spi_reg_master.sv
// Register read/write sequencer feeding an spi_master byte stream.
// Accepts one request, shifts its command frame out one byte at a time,
// collects the full-duplex RX bytes and returns them with a timeout flag.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/ready          : request handshake (rw, addr, wdata)
//   rsp_valid/ready          : response handshake (rdata, err)
//   spi_tx_data/valid/ready  : byte stream towards spi_master
//   spi_rx_data/valid        : received-byte strobe from spi_master
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_rw,
  input  logic [8*ADDR_BYTES-2:0]     req_addr,
  input  logic [8*DATA_BYTES-1:0]     req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [8*DATA_BYTES-1:0]     rsp_rdata,
  output logic                        rsp_err,
  output logic [7:0]                  spi_tx_data,
  output logic                        spi_tx_valid,
  input  logic                        spi_tx_ready,
  input  logic [7:0]                  spi_rx_data,
  input  logic                        spi_rx_valid
);

  localparam int unsigned DW = BYTE_W * DATA_BYTES;
  localparam int unsigned N  = ADDR_BYTES + DATA_BYTES;
  localparam int unsigned FW = BYTE_W * N;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned IW = $clog2(N + 1);

  state_t          state, state_next;
  logic [FW-1:0]   shreg;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tmo;
  logic            rx_last;
  logic            tmo_hit;

  assign rx_last = (idx == IW'(N - 1));
  // Last waiting cycle: the counter would reach TIMEOUT-1 on this edge.
  assign tmo_hit = (tmo == TW'(TIMEOUT - 2));

  // The frame register's top byte is the TX byte, so it is a flop output.
  assign spi_tx_data = shreg[FW-1 -: BYTE_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SEND;
      SEND:    if (spi_tx_ready) state_next = WAIT_RX;
      WAIT_RX: begin
        // A byte arriving on the timeout cycle takes priority over the error.
        if (spi_rx_valid) state_next = rx_last ? RESP : SEND;
        else if (tmo_hit) state_next = RESP;
      end
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready    <= 1'b1;
      spi_tx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
    end else begin
      req_ready    <= (state_next == IDLE);
      spi_tx_valid <= (state_next == SEND);
      rsp_valid    <= (state_next == RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      idx       <= '0;
      tmo       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            shreg     <= FW'(build_frame(req_rw, 31'(req_addr), 32'(req_wdata),
                                         ADDR_BYTES, DATA_BYTES));
            idx       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        SEND: begin
          if (spi_tx_ready) begin
            shreg <= shreg << BYTE_W;
            tmo   <= '0;
          end
        end
        WAIT_RX: begin
          if (spi_rx_valid) begin
            if (idx >= IW'(ADDR_BYTES)) rsp_rdata <= DW'({rsp_rdata, spi_rx_data});
            idx <= idx + 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo_hit) rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

Register-access sequencer directly upstream of `spi_master`. Accepts one register read or write request, serializes it into a command frame of `ADDR_BYTES + DATA_BYTES` bytes on `spi_master`'s byte TX stream, collects the full-duplex RX bytes, and returns read data plus an error flag on a response handshake. One request is in flight at a time. A per-byte timeout guarantees the block never hangs on a missing RX byte.

## Interface

Parameters:
- `ADDR_BYTES`, 1: address bytes per frame (1..4); address width `AW = 8*ADDR_BYTES - 1` (MSB of first byte is R/W flag).
- `DATA_BYTES`, 1: data bytes per frame (1..4); data width `DW = 8*DATA_BYTES`.
- `TIMEOUT`, 4096: max `clk` cycles waiting for each RX byte; must be >= 2.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both high.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_addr` in AW: register address.
- `req_wdata` in DW: write data, ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when both high.
- `rsp_rdata` out DW: data bytes captured from RX (valid for reads and writes).
- `rsp_err` out 1: timeout occurred.
- `spi_tx_data` out 8: byte to `spi_master`.
- `spi_tx_valid` out 1: TX byte valid.
- `spi_tx_ready` in 1: `spi_master` took the byte.
- `spi_rx_data` in 8: byte received by `spi_master`.
- `spi_rx_valid` in 1: single-cycle RX strobe.

## Operation

- Frame, MSB-first, `N = ADDR_BYTES + DATA_BYTES` bytes: `{req_rw, req_addr}` as `ADDR_BYTES` bytes (most significant first), then `req_wdata` most significant byte first for writes, or `0x00` bytes for reads.
- Reset: state IDLE; `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `spi_tx_valid`=0, `spi_tx_data`=0.
- IDLE: `req_ready`=1. On `req_valid`, latch the frame into an N-byte shift register. Clear byte counter, `rsp_rdata` and `rsp_err`. Go to SEND.
- SEND: `spi_tx_valid`=1, `spi_tx_data`=top byte. Hold both stable until `spi_tx_ready`. On handshake, drop `spi_tx_valid`, shift the register, load timeout counter with 0, and go to WAIT_RX.
- WAIT_RX: on `spi_rx_valid`:
  - If the byte index is >= `ADDR_BYTES`, shift `spi_rx_data` into the LSB of `rsp_rdata`.
  - Increment the index.
  - If index == N-1, go to RESP; otherwise go to SEND.
- WAIT_RX timeout: the counter increments each cycle without `spi_rx_valid`. Reaching `TIMEOUT-1` sets `rsp_err`=1 and goes to RESP; the remaining bytes are abandoned.
- RESP: `rsp_valid`=1 with stable `rsp_rdata`/`rsp_err` until `rsp_ready`, then IDLE.
- `spi_rx_valid` outside WAIT_RX is ignored.
- `spi_rx_valid` coinciding with the timeout cycle wins: the byte is accepted and no error is raised.
- Reset mid-frame: immediate return to reset values; `spi_master` is reset by the same `rst`.

## Timing

- Request accepted in cycle t; `spi_tx_valid` high in t+1.
- Next byte's `spi_tx_valid` is high the cycle after the previous `spi_rx_valid`.
- `rsp_valid` is high the cycle after the last `spi_rx_valid`, or after the timeout cycle.
- After the `rsp_ready` handshake, `req_ready` is high the next cycle. Minimum one idle cycle between requests; no back-to-back acceptance.
- All outputs are registered.

## Structure

- Package `spi_reg_pkg`: state enum `{IDLE, SEND, WAIT_RX, RESP}`, byte-width constant, and a function to build the frame from `rw/addr/wdata`.
- No sub-module: the shift register, byte counter and timeout counter are inline.

## Test plan

Bench: `spi_master` (`CLK_RATIO`=16) with MISO looped to MOSI; `clk` at 125 MHz.

- Write, addr 0x12, wdata 0x34 -> TX bytes 0x12, 0x34; `rsp_rdata`=0x34, `rsp_err`=0.
- Read, addr 0x12 -> TX bytes 0x92, 0x00; `rsp_rdata`=0x00, `rsp_err`=0.
- `ADDR_BYTES`=2, `DATA_BYTES`=2, write addr 0x0155, data 0xA3AA -> TX 0x01, 0x55, 0xA3, 0xAA; `rsp_rdata`=0xA3AA.
- `spi_rx_valid` forced low, `TIMEOUT`=64 -> `rsp_valid` with `rsp_err`=1 exactly 64 cycles after the first TX handshake; no further TX bytes.
- Stimulus:
  - `rsp_ready` held low 50 cycles: `rsp_valid`/`rsp_rdata` stay stable and `req_ready`=0 throughout.
  - `rst` pulsed during the second byte: outputs return to reset values the next cycle.
  - A new write then completes normally.
